cdc_stable_capture: RTL and testbench

//  - Downstream stage of the two-flop bus synchroniser, in the destination clock domain.
//  - Watches the synchronised multi-bit bus and accepts a value only after it has held

---
 rtl/cdc_stable_capture_pkg.sv | 21 ++
 rtl/cdc_stability_counter.sv | 58 +++++
 rtl/cdc_stable_capture.sv | 119 +++++++++++
 tb/tb_cdc_stable_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_stable_capture_pkg.sv
// Shared definitions for the stable-capture stage of the bus synchroniser:
// the ceiling-log2 helper used to size the stability counter and the width
// of the optional overflow counter.
package cdc_stable_capture_pkg;

    localparam int OVF_CNT_WIDTH = 16;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 32'sd1;
        r = 32'sd0;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdc_stability_counter.sv
// Stability tracker for the synchronised bus. Holds the last sampled value
// and a saturating count of how many further edges it has been seen
// unchanged. 'stable' is high on the edge at which the value has been sampled
// identically STABLE_CYCLES+1 times in a row; because the count saturates,
// that happens at most once per run of identical samples.
module cdc_stability_counter
    import cdc_stable_capture_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  stable
);

    localparam int CNT_WIDTH = (clog2(STABLE_CYCLES + 32'sd1) > 32'sd0) ?
                               clog2(STABLE_CYCLES + 32'sd1) : 32'sd1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 32'sd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'sd1);

    logic [DATA_WIDTH-1:0] sample_d;
    logic [DATA_WIDTH-1:0] sample_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q;

    // Next-state for the sample register and the saturating run counter.
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        if (data_in != sample_q) begin
            sample_d = data_in;
            cnt_d    = {CNT_WIDTH{1'b0}};
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sample and counter state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= {DATA_WIDTH{1'b0}};
            cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sample = sample_q;
    assign stable = (data_in == sample_q) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/cdc_stable_capture.sv
// Destination-domain capture stage behind a two-flop bus synchroniser.
// A value is committed to data_out once it has been sampled unchanged on
// STABLE_CYCLES+1 consecutive edges and differs from the last committed value
// (the very first qualified value after reset always commits). Each commit is
// presented once on a valid/ready interface; a commit while the previous value
// is still pending overwrites it.
// Optional feature: define STABLE_CAPTURE_OVF_EN to add the 16-bit saturating
// ovf_count output counting such overwrites.
module cdc_stable_capture
    import cdc_stable_capture_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     out_valid
`ifdef STABLE_CAPTURE_OVF_EN
    ,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
`endif
);

    logic [DATA_WIDTH-1:0] sample_s;
    logic                  stable_s;
    logic                  new_value_s;
    logic                  commit_s;

    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  out_valid_d;
    logic                  out_valid_q;
    logic                  have_committed_d;
    logic                  have_committed_q;

    cdc_stability_counter #(
        .DATA_WIDTH    (DATA_WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stability (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .sample  (sample_s),
        .stable  (stable_s)
    );

    // A qualified value only commits if it is new, or nothing has committed yet.
    assign new_value_s = (sample_s != data_out_q) || !have_committed_q;
    assign commit_s    = stable_s && new_value_s;

    // Output register and valid/ready handshake next-state.
    always_comb begin
        data_out_d       = data_out_q;
        out_valid_d      = out_valid_q;
        have_committed_d = have_committed_q;
        if (commit_s) begin
            data_out_d       = sample_s;
            out_valid_d      = 1'b1;
            have_committed_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output and commit-history state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q       <= {DATA_WIDTH{1'b0}};
            out_valid_q      <= 1'b0;
            have_committed_q <= 1'b0;
        end else begin
            data_out_q       <= data_out_d;
            out_valid_q      <= out_valid_d;
            have_committed_q <= have_committed_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

`ifdef STABLE_CAPTURE_OVF_EN
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_ONE = {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_MAX = {OVF_CNT_WIDTH{1'b1}};

    logic                     overflow_s;
    logic [OVF_CNT_WIDTH-1:0] ovf_count_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_count_q;

    // Overwrite of an unconsumed value; a same-edge consume is not an overflow.
    assign overflow_s = commit_s && out_valid_q && !out_ready;

    // Saturating overflow counter next-state.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (overflow_s && (ovf_count_q != OVF_MAX)) begin
            ovf_count_d = ovf_count_q + OVF_ONE;
        end else begin
            ovf_count_d = ovf_count_q;
        end
    end

    // Overflow counter state, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count_q <= {OVF_CNT_WIDTH{1'b0}};
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_cdc_stable_capture.sv
// Self-checking bench for cdc_stable_capture: directed scenarios with literal
// expectations plus randomized stimulus, all checked every cycle against a
// run-length reference model. Define STABLE_CAPTURE_OVF_EN to also check
// ovf_count.
module tb_cdc_stable_capture;

    localparam int DW = 32;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = 32'hFFFF_FFFF;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;
`ifdef STABLE_CAPTURE_OVF_EN
    logic [15:0]   ovf_count;
`endif

    cdc_stable_capture #(
        .DATA_WIDTH    (DW),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid)
`ifdef STABLE_CAPTURE_OVF_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: length of the current run of identical samples.
    // Reset behaves like one sample of zero already taken.
    logic [DW-1:0] m_prev;
    int            m_run;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_have;
    int            m_ovf;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_run   = 1;
        m_data  = '0;
        m_valid = 1'b0;
        m_have  = 1'b0;
        m_ovf   = 0;
    endtask

    task automatic model_step(input logic [DW-1:0] din, input logic rdy);
        bit commit;
        if (din == m_prev) begin
            m_run++;
        end else begin
            m_prev = din;
            m_run  = 1;
        end
        commit = (m_run == SC + 1) && (!m_have || din != m_data);
        if (commit && m_valid && !rdy && m_ovf < 65535) m_ovf++;
        if (commit) begin
            m_data  = din;
            m_valid = 1'b1;
            m_have  = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the next active edge.
    task automatic cycle(input logic [DW-1:0] din, input logic rdy);
        data_in   = din;
        out_ready = rdy;
        model_step(din, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset mid-cycle and releases at a negedge.
    task automatic do_reset(input logic [DW-1:0] din, input int hold);
        rst     = 1'b1;
        data_in = din;
        model_reset();
        #1;
        chk("async_rst_data", data_out, 32'h0);
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_data_out", data_out, m_data);
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
`ifdef STABLE_CAPTURE_OVF_EN
            chk("cyc_ovf_count", {16'b0, ovf_count}, m_ovf[31:0]);
`endif
        end
    end

    initial begin
        int first;
        int seen;
        logic [DW-1:0] v;
        int len;
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset(32'hFFFF_FFFF, 2);
        chk("reset_data", data_out, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
`ifdef STABLE_CAPTURE_OVF_EN
        chk("reset_ovf", {16'b0, ovf_count}, 32'h0);
`endif

        // Basic qualify: A5 held, commits on the 4th edge, then never again
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(32'h0000_00A5, 1'b1);
            if (out_valid && first == 0) first = k;
        end
        chk("basic_latency", first, 32'd4);
        chk("basic_data", data_out, 32'h0000_00A5);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(32'h0000_00A5, 1'b1);
            if (out_valid) seen++;
        end
        chk("basic_no_recommit", seen, 32'd0);

        // Glitch reject
        cycle(32'h0000_005A, 1'b1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(32'h0000_00A5, 1'b1);
            if (out_valid) seen++;
        end
        chk("glitch_no_commit", seen, 32'd0);
        chk("glitch_data", data_out, 32'h0000_00A5);

        // Backpressure / overflow
        repeat (4) cycle(32'h1, 1'b0);
        chk("bp_first_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_first_data", data_out, 32'h1);
        repeat (4) cycle(32'h2, 1'b0);
        chk("ovf_data", data_out, 32'h2);
        chk("ovf_valid", {31'b0, out_valid}, 32'h1);
`ifdef STABLE_CAPTURE_OVF_EN
        chk("ovf_count_1", {16'b0, ovf_count}, 32'h1);
`endif
        cycle(32'h2, 1'b1);
        chk("ovf_consumed", {31'b0, out_valid}, 32'h0);

        // Simultaneous commit and consume
        repeat (4) cycle(32'h3, 1'b0);
        chk("sim_pre_data", data_out, 32'h3);
        repeat (3) cycle(32'h4, 1'b0);
        chk("sim_hold_data", data_out, 32'h3);
        cycle(32'h4, 1'b1);
        chk("sim_data", data_out, 32'h4);
        chk("sim_valid", {31'b0, out_valid}, 32'h1);
`ifdef STABLE_CAPTURE_OVF_EN
        chk("sim_ovf_unchanged", {16'b0, ovf_count}, 32'h1);
`endif
        cycle(32'h4, 1'b1);

        // Reset mid-qualification
        repeat (2) cycle(32'h7, 1'b0);
        do_reset(32'h7, 1);
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(32'h7, 1'b0);
            if (out_valid && first == 0) first = k;
        end
        chk("rst_mid_latency", first, 32'd4);
        chk("rst_mid_data", data_out, 32'h7);

        // Zero commits after reset
        do_reset(32'h0, 1);
        repeat (4) cycle(32'h0, 1'b0);
        chk("zero_valid", {31'b0, out_valid}, 32'h1);
        chk("zero_data", data_out, 32'h0);

        // Randomized runs with random backpressure and occasional reset
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset($urandom, int'($urandom_range(1, 2)));
            end
            v   = ($urandom_range(0, 7) == 0) ? $urandom : DW'($urandom_range(0, 3));
            len = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++) begin
                cycle(v, 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
